// File: rtl/vip_amba_apb_cmdq_pkg.sv
// Shared types and constants for the APB command queue.
package vip_amba_apb_cmdq_pkg;

  // Sequencer states
  typedef enum logic [2:0] {
    S_IDLE,
    S_REQ,
    S_SETUP,
    S_ACCESS,
    S_CHECK,
    S_RESP,
    S_COOL
  } cmdq_state_t;

  // Default command layout (32-bit address/data), used as the FIFO's default payload
  localparam int unsigned CMDQ_ADDR_W = 32;
  localparam int unsigned CMDQ_DATA_W = 32;

  typedef struct packed {
    logic                     rd_wr;
    logic [CMDQ_ADDR_W-1:0]   addr;
    logic [CMDQ_DATA_W/8-1:0] strb;
    logic [CMDQ_DATA_W-1:0]   wdata;
  } cmdq_cmd_t;

  // Idle cycles after a timeout so the bridge's forced return to IDLE settles
  localparam int unsigned COOL_CYCLES = 2;

endpackage

// File: rtl/vip_amba_apb_cmdq_fifo.sv
// Synchronous command FIFO with a struct-wide payload, full/empty flags and count.
module vip_amba_apb_cmdq_fifo
  import vip_amba_apb_cmdq_pkg::*;
#(
  parameter int unsigned DEPTH     = 4,
  parameter type         payload_t = cmdq_cmd_t
) (
  input  logic                     PCLK,
  input  logic                     PRESET,
  input  logic                     push,
  input  payload_t                 wr_data,
  input  logic                     pop,
  output payload_t                 rd_data,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

  payload_t        mem [DEPTH];
  logic [AW-1:0]   wr_ptr;
  logic [AW-1:0]   rd_ptr;
  logic            do_push;
  logic            do_pop;

  assign full    = (count == FULL_CNT);
  assign empty   = (count == '0);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign rd_data = mem[rd_ptr];

  // Storage write; contents need no reset since count gates visibility
  always_ff @(posedge PCLK) begin
    if (do_push) mem[wr_ptr] <= wr_data;
  end

  // Pointer and occupancy tracking
  always_ff @(posedge PCLK or posedge PRESET) begin
    if (PRESET) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/vip_amba_apb_cmd_queue.sv
// Queues CPU-side APB commands and issues them one at a time to the APB bridge
// BFM CPU port, returning one response per command in push order.
// Optional: define VIP_AMBA_APB_CMDQ_RETRY_EN to reissue a command once after
// its first timeout.
module vip_amba_apb_cmd_queue
  import vip_amba_apb_cmdq_pkg::*;
#(
  parameter int unsigned ADDRESS_WIDTH = 32,
  parameter int unsigned DATA_WIDTH    = 32,
  parameter int unsigned DATA_STROBE   = DATA_WIDTH/8,
  parameter int unsigned CMD_DEPTH     = 4
) (
  input  logic                     PCLK,
  input  logic                     PRESET,
  input  logic                     cmd_valid,
  output logic                     cmd_ready,
  input  logic                     cmd_rd_wr,
  input  logic [ADDRESS_WIDTH-1:0] cmd_addr,
  input  logic [DATA_STROBE-1:0]   cmd_strb,
  input  logic [DATA_WIDTH-1:0]    cmd_wdata,
  output logic                     rsp_valid,
  input  logic                     rsp_ready,
  output logic [DATA_WIDTH-1:0]    rsp_rdata,
  output logic                     rsp_err,
  output logic                     rsp_timeout,
  output logic                     rsp_retried,
  output logic                     bridge_resetn,
  output logic                     bridge_valid_txn,
  output logic                     bridge_slave_sel,
  output logic                     bridge_rd_wr,
  output logic [ADDRESS_WIDTH-1:0] bridge_address,
  output logic [DATA_STROBE-1:0]   bridge_strb,
  output logic [DATA_WIDTH-1:0]    bridge_wdata,
  input  logic                     bridge_ready_for_txn,
  input  logic                     bridge_done,
  input  logic                     bridge_err,
  input  logic                     bridge_timeout,
  input  logic [DATA_WIDTH-1:0]    bridge_rdata
);

  typedef struct packed {
    logic                     rd_wr;
    logic [ADDRESS_WIDTH-1:0] addr;
    logic [DATA_STROBE-1:0]   strb;
    logic [DATA_WIDTH-1:0]    wdata;
  } cmd_t;

  cmdq_state_t                  state;
  cmd_t                         push_cmd;
  cmd_t                         head_cmd;
  cmd_t                         hold;
  logic                         fifo_full;
  logic                         fifo_empty;
  logic [$clog2(CMD_DEPTH):0]   fifo_count;
  logic                         fifo_pop;
  logic [1:0]                   cool_cnt;
  logic                         unused_sig;

  // Completion is taken from ready_for_txn, which covers both PREADY and PSLVERR aborts
  assign unused_sig = ^{bridge_done, fifo_count};

  assign push_cmd  = '{rd_wr: cmd_rd_wr, addr: cmd_addr, strb: cmd_strb, wdata: cmd_wdata};
  assign cmd_ready = bridge_resetn && !fifo_full;
  assign fifo_pop  = (state == S_IDLE) && !fifo_empty;

  assign bridge_slave_sel = bridge_valid_txn;
  assign bridge_rd_wr     = hold.rd_wr;
  assign bridge_address   = hold.addr;
  assign bridge_strb      = hold.strb;
  assign bridge_wdata     = hold.wdata;

  vip_amba_apb_cmdq_fifo #(
    .DEPTH     (CMD_DEPTH),
    .payload_t (cmd_t)
  ) u_fifo (
    .PCLK    (PCLK),
    .PRESET  (PRESET),
    .push    (cmd_valid && cmd_ready),
    .wr_data (push_cmd),
    .pop     (fifo_pop),
    .rd_data (head_cmd),
    .full    (fifo_full),
    .empty   (fifo_empty),
    .count   (fifo_count)
  );

  // Bridge reset follows PRESET release by one registered edge
  always_ff @(posedge PCLK or posedge PRESET) begin
    if (PRESET) bridge_resetn <= 1'b0;
    else        bridge_resetn <= 1'b1;
  end

`ifdef VIP_AMBA_APB_CMDQ_RETRY_EN
  logic retried_q;
  assign rsp_retried = retried_q;
`else
  assign rsp_retried = 1'b0;
`endif

  // Command sequencer: one outstanding command, registered bridge and response outputs
  always_ff @(posedge PCLK or posedge PRESET) begin
    if (PRESET) begin
      state            <= S_IDLE;
      hold             <= '0;
      bridge_valid_txn <= 1'b0;
      rsp_valid        <= 1'b0;
      rsp_rdata        <= '0;
      rsp_err          <= 1'b0;
      rsp_timeout      <= 1'b0;
      cool_cnt         <= '0;
`ifdef VIP_AMBA_APB_CMDQ_RETRY_EN
      retried_q        <= 1'b0;
`endif
    end else begin
      case (state)
        S_IDLE: begin
          if (!fifo_empty) begin
            hold             <= head_cmd;
            bridge_valid_txn <= 1'b1;
            rsp_rdata        <= '0;
            rsp_err          <= 1'b0;
            rsp_timeout      <= 1'b0;
`ifdef VIP_AMBA_APB_CMDQ_RETRY_EN
            retried_q        <= 1'b0;
`endif
            state            <= S_REQ;
          end
        end
        S_REQ: begin
          if (bridge_ready_for_txn) state <= S_SETUP;
        end
        S_SETUP: begin
          bridge_valid_txn <= 1'b0;
          if (bridge_timeout) begin
            rsp_timeout <= 1'b1;
            rsp_err     <= 1'b0;
            cool_cnt    <= 2'(COOL_CYCLES - 1);
            state       <= S_COOL;
          end else begin
            state <= S_ACCESS;
          end
        end
        S_ACCESS: begin
          if (bridge_timeout) begin
            rsp_timeout <= 1'b1;
            rsp_err     <= 1'b0;
            cool_cnt    <= 2'(COOL_CYCLES - 1);
            state       <= S_COOL;
          end else if (bridge_ready_for_txn) begin
            rsp_rdata <= hold.rd_wr ? '0 : bridge_rdata;
            state     <= S_CHECK;
          end
        end
        S_CHECK: begin
          // Bridge error flag is valid one cycle after the access ends
          rsp_err   <= bridge_err;
          rsp_valid <= 1'b1;
          state     <= S_RESP;
        end
        S_COOL: begin
          if (cool_cnt == '0) begin
`ifdef VIP_AMBA_APB_CMDQ_RETRY_EN
            if (!retried_q) begin
              retried_q        <= 1'b1;
              rsp_timeout      <= 1'b0;
              bridge_valid_txn <= 1'b1;
              state            <= S_REQ;
            end else begin
              rsp_valid <= 1'b1;
              state     <= S_RESP;
            end
`else
            rsp_valid <= 1'b1;
            state     <= S_RESP;
`endif
          end else begin
            cool_cnt <= cool_cnt - 1'b1;
          end
        end
        S_RESP: begin
          if (rsp_ready) begin
            rsp_valid <= 1'b0;
            state     <= S_IDLE;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_vip_amba_apb_cmd_queue.sv
// Directed bench for vip_amba_apb_cmd_queue with a small behavioural bridge model.
module tb_vip_amba_apb_cmd_queue;

  logic        PCLK = 1'b0;
  logic        PRESET = 1'b1;
  logic        cmd_valid = 1'b0;
  logic        cmd_ready;
  logic        cmd_rd_wr = 1'b0;
  logic [31:0] cmd_addr = '0;
  logic [3:0]  cmd_strb = '0;
  logic [31:0] cmd_wdata = '0;
  logic        rsp_valid;
  logic        rsp_ready = 1'b0;
  logic [31:0] rsp_rdata;
  logic        rsp_err, rsp_timeout, rsp_retried;
  logic        bridge_resetn, bridge_valid_txn, bridge_slave_sel, bridge_rd_wr;
  logic [31:0] bridge_address;
  logic [3:0]  bridge_strb;
  logic [31:0] bridge_wdata;
  logic        bridge_ready_for_txn, bridge_done, bridge_err, bridge_timeout;
  logic [31:0] bridge_rdata;

  int unsigned errors = 0;
  int unsigned checks = 0;
  int          cyc = 0;

  vip_amba_apb_cmd_queue #(
    .ADDRESS_WIDTH (32),
    .DATA_WIDTH    (32),
    .DATA_STROBE   (4),
    .CMD_DEPTH     (4)
  ) dut (
    .PCLK                 (PCLK),
    .PRESET               (PRESET),
    .cmd_valid            (cmd_valid),
    .cmd_ready            (cmd_ready),
    .cmd_rd_wr            (cmd_rd_wr),
    .cmd_addr             (cmd_addr),
    .cmd_strb             (cmd_strb),
    .cmd_wdata            (cmd_wdata),
    .rsp_valid            (rsp_valid),
    .rsp_ready            (rsp_ready),
    .rsp_rdata            (rsp_rdata),
    .rsp_err              (rsp_err),
    .rsp_timeout          (rsp_timeout),
    .rsp_retried          (rsp_retried),
    .bridge_resetn        (bridge_resetn),
    .bridge_valid_txn     (bridge_valid_txn),
    .bridge_slave_sel     (bridge_slave_sel),
    .bridge_rd_wr         (bridge_rd_wr),
    .bridge_address       (bridge_address),
    .bridge_strb          (bridge_strb),
    .bridge_wdata         (bridge_wdata),
    .bridge_ready_for_txn (bridge_ready_for_txn),
    .bridge_done          (bridge_done),
    .bridge_err           (bridge_err),
    .bridge_timeout       (bridge_timeout),
    .bridge_rdata         (bridge_rdata)
  );

  always #5 PCLK = ~PCLK;
  always @(posedge PCLK) cyc <= cyc + 1;

  // ---------------- bridge model ----------------
  typedef enum logic [1:0] {B_IDLE, B_SETUP, B_ACCESS, B_TMO} bst_t;
  bst_t        bst = B_IDLE;
  int          wcnt = 0;
  logic        berr = 1'b0;
  int          req_cnt = 0;
  int          vcnt = 0;
  logic [31:0] last_addr = '0;
  logic [31:0] last_wdata = '0;
  logic [3:0]  last_strb = '0;
  logic        last_rw = 1'b0;

  int          cfg_wait = 0;
  int          cfg_tmo = 3;
  logic        cfg_slverr = 1'b0;
  logic        cfg_hang = 1'b0;
  logic        cfg_fixed = 1'b0;
  logic [31:0] cfg_rdata = '0;

  always @(posedge PCLK) if (bridge_valid_txn) vcnt <= vcnt + 1;

  always @(posedge PCLK or negedge bridge_resetn) begin
    if (!bridge_resetn) begin
      bst  <= B_IDLE;
      wcnt <= 0;
      berr <= 1'b0;
    end else begin
      case (bst)
        B_IDLE: if (bridge_valid_txn && bridge_slave_sel) begin
          bst        <= B_SETUP;
          berr       <= 1'b0;
          req_cnt    <= req_cnt + 1;
          last_addr  <= bridge_address;
          last_wdata <= bridge_wdata;
          last_strb  <= bridge_strb;
          last_rw    <= bridge_rd_wr;
        end
        B_SETUP: begin
          bst  <= B_ACCESS;
          wcnt <= 0;
        end
        B_ACCESS: begin
          if (cfg_hang) begin
            if (wcnt >= cfg_tmo) bst <= B_TMO;
            else wcnt <= wcnt + 1;
          end else if (wcnt >= cfg_wait) begin
            bst  <= B_IDLE;
            berr <= cfg_slverr;
          end else begin
            wcnt <= wcnt + 1;
          end
        end
        default: bst <= B_IDLE;
      endcase
    end
  end

  always_comb begin
    bridge_ready_for_txn = (bst == B_IDLE) ||
                           (bst == B_ACCESS && !cfg_hang && wcnt >= cfg_wait);
    bridge_done    = (bst == B_ACCESS) && !cfg_hang && (wcnt >= cfg_wait) && !cfg_slverr;
    bridge_timeout = (bst == B_TMO);
    bridge_err     = berr;
    bridge_rdata   = '0;
    if (bst == B_ACCESS)
      bridge_rdata = cfg_fixed ? cfg_rdata : {16'hC0DE, last_addr[15:0]};
  end

  // ---------------- helpers ----------------
  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge PCLK);
    #1;
  endtask

  task automatic push(input logic rw, input logic [31:0] a, input logic [3:0] s,
                      input logic [31:0] wd, output int n);
    logic took;
    took      = 1'b0;
    cmd_valid = 1'b1;
    cmd_rd_wr = rw;
    cmd_addr  = a;
    cmd_strb  = s;
    cmd_wdata = wd;
    for (int i = 0; i < 100 && !took; i++) begin
      took = cmd_ready;
      tick();
    end
    cmd_valid = 1'b0;
    n = cyc;
    check("push_accept", took, 1);
  endtask

  task automatic wait_rsp(output int n);
    for (int i = 0; i < 200 && !rsp_valid; i++) tick();
    n = cyc;
    check("rsp_arrives", rsp_valid, 1);
  endtask

  task automatic take_rsp();
    rsp_ready = 1'b1;
    tick();
    rsp_ready = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int   n, m, v0, r0;
    logic saw;
    logic exp_retry;
    int   exp_reqs;
`ifdef VIP_AMBA_APB_CMDQ_RETRY_EN
    exp_retry = 1'b1;
    exp_reqs  = 2;
`else
    exp_retry = 1'b0;
    exp_reqs  = 1;
`endif

    // Reset state
    repeat (3) tick();
    check("rst_ctrl", {cmd_ready, rsp_valid, rsp_err, rsp_timeout, rsp_retried,
                       bridge_resetn, bridge_valid_txn, bridge_slave_sel}, 0);
    check("rst_data", {bridge_address, rsp_rdata}, 0);
    PRESET = 1'b0;
    tick();
    check("rel_bridge_resetn", bridge_resetn, 1);
    check("rel_cmd_ready", cmd_ready, 1);

    // T1: zero-wait write
    v0 = vcnt;
    push(1'b1, 32'h10, 4'hF, 32'hDEADBEEF, n);
    wait_rsp(m);
    check("t1_latency", m - n, 5);
    check("t1_valid_cycles", vcnt - v0, 2);
    check("t1_bridge_addr", last_addr, 32'h10);
    check("t1_bridge_wdata", last_wdata, 32'hDEADBEEF);
    check("t1_bridge_strb_rw", {last_strb, last_rw}, 5'h1F);
    check("t1_rsp", {rsp_rdata, rsp_err, rsp_timeout, rsp_retried}, 0);
    take_rsp();
    check("t1_rsp_drop", rsp_valid, 0);

    // T2: read with 3 PREADY-low cycles
    cfg_wait = 3; cfg_fixed = 1'b1; cfg_rdata = 32'h12345678;
    push(1'b0, 32'h20, 4'h0, 32'h0, n);
    wait_rsp(m);
    check("t2_latency", m - n, 8);
    check("t2_rdata", rsp_rdata, 32'h12345678);
    check("t2_flags", {rsp_err, rsp_timeout}, 0);
    take_rsp();
    cfg_wait = 0; cfg_fixed = 1'b0;

    // T3: fill the queue with responses stalled; order preserved
    for (int i = 0; i < 5; i++) push(1'b0, 32'h100 + 32'(4*i), 4'h0, 32'h0, n);
    check("t3_full", cmd_ready, 0);
    saw = 1'b0;
    for (int i = 0; i < 8; i++) begin
      saw |= cmd_ready;
      tick();
    end
    check("t3_full_hold", saw, 0);
    wait_rsp(m);
    check("t3_rdata0", rsp_rdata, 32'hC0DE0100);
    take_rsp();
    push(1'b0, 32'h114, 4'h0, 32'h0, n);
    for (int i = 1; i < 6; i++) begin
      wait_rsp(m);
      check($sformatf("t3_rdata%0d", i), rsp_rdata, 32'hC0DE0100 + 32'(4*i));
      take_rsp();
    end

    // T4: PSLVERR then clean write
    cfg_slverr = 1'b1;
    push(1'b1, 32'h30, 4'hF, 32'h1, n);
    wait_rsp(m);
    check("t4_err", {rsp_err, rsp_timeout}, 2'b10);
    take_rsp();
    cfg_slverr = 1'b0;
    push(1'b1, 32'h34, 4'hF, 32'h2, n);
    wait_rsp(m);
    check("t4_noerr", {rsp_err, rsp_timeout}, 2'b00);
    take_rsp();

    // T5: slave never ready -> timeout
    cfg_hang = 1'b1; cfg_tmo = 3;
    r0 = req_cnt;
    push(1'b1, 32'h50, 4'hF, 32'h3, n);
    wait_rsp(m);
    check("t5_flags", {rsp_err, rsp_timeout}, 2'b01);
    check("t5_retried", rsp_retried, exp_retry);
    check("t5_reqs", req_cnt - r0, exp_reqs);
    take_rsp();
    cfg_hang = 1'b0;

    // T6: reset during ACCESS with two queued
    cfg_wait = 20;
    push(1'b0, 32'h60, 4'h0, 32'h0, n);
    push(1'b0, 32'h64, 4'h0, 32'h0, n);
    push(1'b0, 32'h68, 4'h0, 32'h0, n);
    for (int i = 0; i < 50 && bst != B_ACCESS; i++) tick();
    check("t6_in_access", bst == B_ACCESS, 1);
    PRESET = 1'b1;
    #1;
    check("t6_rst_ctrl", {cmd_ready, rsp_valid, rsp_err, rsp_timeout, rsp_retried,
                          bridge_resetn, bridge_valid_txn, bridge_slave_sel}, 0);
    check("t6_rst_data", {bridge_address, rsp_rdata}, 0);
    tick(); tick();
    PRESET = 1'b0;
    cfg_wait = 0;
    v0 = vcnt; r0 = req_cnt; saw = 1'b0;
    for (int i = 0; i < 20; i++) begin
      tick();
      saw |= rsp_valid;
    end
    check("t6_no_rsp", saw, 0);
    check("t6_no_req", {32'(req_cnt - r0), 32'(vcnt - v0)}, 0);
    check("t6_ready", cmd_ready, 1);
    push(1'b1, 32'h70, 4'hF, 32'h4, n);
    wait_rsp(m);
    check("t6_recover_latency", m - n, 5);
    check("t6_recover_addr", last_addr, 32'h70);
    take_rsp();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
